// File: rtl/vmul_pkg.sv
// Shared definitions for the sequential limb-serial multiplier: FSM states,
// limb width and the limb-count helper.
package vmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LIMB_W = 8;

    function automatic int num_limbs(input int opw);
        return opw / LIMB_W;
    endfunction

endpackage

// File: rtl/vedic8x8.sv
// Purely combinational 8x8 unsigned Vedic (Urdhva Tiryagbhyam) multiplier,
// built recursively from 2x2 and 4x4 crosswise blocks.
module vedic8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
        logic t1, c1, hh;
        t1 = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1 = (x[1] & y[0]) & (x[0] & y[1]);
        hh = x[1] & y[1];
        return {hh & c1, hh ^ c1, t1, x[0] & y[0]};
    endfunction

    function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] q0, q1, q2, q3;
        q0 = {4'b0, v2(x[1:0], y[1:0])};
        q1 = {4'b0, v2(x[3:2], y[1:0])};
        q2 = {4'b0, v2(x[1:0], y[3:2])};
        q3 = {4'b0, v2(x[3:2], y[3:2])};
        return q0 + (q1 << 2) + (q2 << 2) + (q3 << 4);
    endfunction

    logic [15:0] q0, q1, q2, q3;

    always_comb begin
        q0 = {8'b0, v4(a[3:0], b[3:0])};
        q1 = {8'b0, v4(a[7:4], b[3:0])};
        q2 = {8'b0, v4(a[3:0], b[7:4])};
        q3 = {8'b0, v4(a[7:4], b[7:4])};
        p  = q0 + (q1 << 4) + (q2 << 4) + (q3 << 8);
    end

endmodule

// File: rtl/vmul_limb_sel.sv
// Picks the idx-th 8-bit limb (little-endian) out of an OPW-bit operand word.
module vmul_limb_sel
    import vmul_pkg::*;
#(
    parameter int OPW = 16,
    parameter int IW  = 1
) (
    input  logic [OPW-1:0]    word,
    input  logic [IW-1:0]     idx,
    output logic [LIMB_W-1:0] limb
);

    logic [OPW-1:0] shifted;

    assign shifted = word >> (32'(idx) * 32'(LIMB_W));
    assign limb    = shifted[LIMB_W-1:0];

endmodule

// File: rtl/vedic_mul_seq.sv
// Multi-cycle OPW x OPW unsigned multiplier reusing one vedic8x8 core, one limb
// pair per cycle. Define VMUL_SEQ_ZERO_SKIP_EN to bypass MUL when an operand is 0.
module vedic_mul_seq
    import vmul_pkg::*;
#(
    parameter int OPW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*OPW-1:0] p,
    output logic             busy
);

    localparam int NL = num_limbs(OPW);
    localparam int IW = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [IW-1:0] LAST = IW'(NL - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and p is held
    // stable while out_valid waits for out_ready.
    state_t            state, state_next;
    logic [OPW-1:0]    a_reg, b_reg;
    logic [2*OPW-1:0]  acc, term;
    logic [IW-1:0]     i_idx, j_idx;
    logic [LIMB_W-1:0] a_limb, b_limb;
    logic [15:0]       core_p;
    logic [31:0]       shamt;
    logic              accept, last_pair, skip;

    assign accept    = in_valid && in_ready;
    assign last_pair = (i_idx == LAST) && (j_idx == LAST);
`ifdef VMUL_SEQ_ZERO_SKIP_EN
    assign skip = (a == '0) || (b == '0);
`else
    assign skip = 1'b0;
`endif

    vmul_limb_sel #(.OPW(OPW), .IW(IW)) u_sel_a (.word(a_reg), .idx(i_idx), .limb(a_limb));
    vmul_limb_sel #(.OPW(OPW), .IW(IW)) u_sel_b (.word(b_reg), .idx(j_idx), .limb(b_limb));
    vedic8x8 u_core (.a(a_limb), .b(b_limb), .p(core_p));

    assign shamt = (32'(i_idx) + 32'(j_idx)) * 32'(LIMB_W);
    assign term  = {{(2*OPW-16){1'b0}}, core_p} << shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = skip ? DONE : MUL;
            end
            MUL: begin
                if (last_pair) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign p    = acc;

    // i sweeps the a-limbs fastest; j advances each time i wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
        end else if (state == MUL) begin
            acc <= acc + term;
            if (i_idx == LAST) begin
                i_idx <= '0;
                j_idx <= (j_idx == LAST) ? '0 : j_idx + 1'b1;
            end else begin
                i_idx <= i_idx + 1'b1;
            end
        end
    end

endmodule
